// File: rtl/md_pkg.sv
// Shared types for the multiply/divide unit: operation encoding, FSM states
// and small classification helpers used by the unit and its arithmetic block.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_muldiv(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result for a latched mult/div operation, including the
// signed-division sign rules and divide-by-zero detection.
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n,
  output logic             div_zero
);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   quo_u;
  logic [WIDTH-1:0]   rem_u;

  // Extending to 2*WIDTH first makes the truncated product exact for both signednesses.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Signed division runs on magnitudes; MIN_INT / -1 then wraps back to MIN_INT with remainder 0.
  assign a_neg    = (op == MD_DIV) && a[WIDTH-1];
  assign b_neg    = (op == MD_DIV) && b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = md_is_div(op) && (b == '0);
  assign divisor  = (b_mag == '0) ? WIDTH'(1) : b_mag;
  assign quo_u    = a_mag / divisor;
  assign rem_u    = a_mag % divisor;

  always_comb begin
    hi_n = '0;
    lo_n = '0;
    case (op)
      MD_MULT:  {hi_n, lo_n} = prod_s;
      MD_MULTU: {hi_n, lo_n} = prod_u;
      MD_DIV: begin
        lo_n = (a_neg ^ b_neg) ? -quo_u : quo_u;
        hi_n = a_neg ? -rem_u : rem_u;
      end
      MD_DIVU: begin
        lo_n = quo_u;
        hi_n = rem_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div for a fixed
// per-operation latency and flags busy so decode can stall on it.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  md_op_t           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  md_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  md_op_t           op_reg, op_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic             done_reg, done_next;

  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic             div_zero;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op       (op_reg),
    .a        (a_reg),
    .b        (b_reg),
    .hi_n     (hi_n),
    .lo_n     (lo_n),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      op_reg    <= MD_NONE;
      a_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          if (md_is_muldiv(op_i)) begin
            state_next = ST_BUSY;
            op_next    = op_i;
            a_next     = a_i;
            b_next     = b_i;
            cnt_next   = md_is_div(op_i) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          end else if (op_i == MD_MTHI) begin
            hi_next = a_i;
          end else if (op_i == MD_MTLO) begin
            lo_next = a_i;
          end
        end
      end
      ST_BUSY: begin
        // New starts are dropped here; the decode stall is expected to hold them off.
        if (cnt_reg == '0) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
          if (!div_zero) begin
            hi_next = hi_n;
            lo_next = lo_n;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy_o = (state_reg == ST_BUSY);
  assign done_o = done_reg;
  assign hi_o   = hi_reg;
  assign lo_o   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a vector table on the default build plus
// hand sequences for busy/reset interaction and a 16-bit single-cycle build.
module tb_md_unit;
  import md_pkg::*;

  typedef struct {
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  md_op_t      op = MD_NONE;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        s_start = 1'b0;
  md_op_t      s_op = MD_NONE;
  logic [15:0] s_a = '0;
  logic [15:0] s_b = '0;
  logic        s_busy, s_done;
  logic [15:0] s_hi, s_lo;

  int checks = 0;
  int errors = 0;
  vec_t vecs[10];

  always #5 clk = ~clk;

  md_unit dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .start_i(s_start), .op_i(s_op), .a_i(s_a), .b_i(s_b),
    .busy_o(s_busy), .done_o(s_done), .hi_o(s_hi), .lo_o(s_lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives one start strobe; returns at the falling edge of the first cycle after it was sampled.
  task automatic issue(input md_op_t o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
  endtask

  task automatic run_vec(input int i);
    int busy_n, done_n, done_at;
    issue(MD_MTHI, vecs[i].pre_hi, '0);
    check("mthi", hi, vecs[i].pre_hi);
    issue(MD_MTLO, vecs[i].pre_lo, '0);
    check("mtlo", lo, vecs[i].pre_lo);
    issue(vecs[i].op, vecs[i].a, vecs[i].b);
    busy_n = 0; done_n = 0; done_at = -1;
    for (int c = 0; c < 16; c++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      @(negedge clk);
    end
    check("busy_cycles", busy_n, vecs[i].cyc);
    check("done_pulses", done_n, 1);
    check("done_cycle", done_at, vecs[i].cyc);
    check("hi", hi, vecs[i].exp_hi);
    check("lo", lo, vecs[i].exp_lo);
    $display("txn %0d op=%s a=%h b=%h busy=%0d hi=%h lo=%h", i, vecs[i].op.name(),
             vecs[i].a, vecs[i].b, busy_n, hi, lo);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int bn, dn;
    //         op        a             b             pre_hi        pre_lo        exp_hi        exp_lo        cyc
    vecs[0] = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h11111111, 32'h22222222, 32'h00000000, 32'h80000000, 10};
    vecs[4] = '{MD_DIVU,  32'h00000064, 32'h00000000, 32'h00000012, 32'h00000034, 32'h00000012, 32'h00000034, 10};
    vecs[5] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6] = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h00000000, 32'h00000000, 32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[7] = '{MD_DIV,   32'hFFFFFF00, 32'h00000000, 32'h0000AAAA, 32'h00005555, 32'h0000AAAA, 32'h00005555, 10};
    vecs[8] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000, 32'h40000000, 32'h00000000, 5};
    vecs[9] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000001, 5};

    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst16_busy", s_busy, 0);
    check("rst16_hilo", {s_hi, s_lo}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i);

    // DIV 100/7 with an MTLO mid-flight and a MULT on the final busy cycle: both dropped.
    issue(MD_DIV, 32'd100, 32'd7);
    for (int i = 1; i <= 10; i++) begin
      check("seq_busy", busy, 1);
      if (i == 3) begin
        start = 1'b1; op = MD_MTLO; a = 32'd55;
      end else if (i == 10) begin
        start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd3;
      end else begin
        start = 1'b0; op = MD_NONE;
      end
      @(negedge clk);
    end
    start = 1'b0; op = MD_NONE;
    check("seq_end_busy", busy, 0);
    check("seq_done", done, 1);
    check("seq_lo", lo, 32'h0000000E);
    check("seq_hi", hi, 32'h00000002);
    @(negedge clk);
    check("seq_late_start_busy", busy, 0);
    check("seq_done_once", done, 0);
    $display("txn busy-seq hi=%h lo=%h", hi, lo);

    // 16-bit single-cycle build: starts accepted every second cycle.
    @(negedge clk);
    s_start = 1'b1; s_op = MD_MULT; s_a = 16'h0003; s_b = 16'hFFFE;
    @(negedge clk);
    s_start = 1'b0; s_op = MD_NONE;
    check("w16_mult_busy", s_busy, 1);
    @(negedge clk);
    check("w16_mult_idle", s_busy, 0);
    check("w16_mult_done", s_done, 1);
    check("w16_mult_hilo", {s_hi, s_lo}, 32'hFFFFFFFA);
    s_start = 1'b1; s_op = MD_DIVU; s_a = 16'd100; s_b = 16'd7;
    @(negedge clk);
    s_start = 1'b0; s_op = MD_NONE;
    check("w16_divu_busy", s_busy, 1);
    check("w16_divu_nodone", s_done, 0);
    @(negedge clk);
    check("w16_divu_done", s_done, 1);
    check("w16_divu_hilo", {s_hi, s_lo}, 32'h0002000E);
    s_start = 1'b1; s_op = MD_DIV; s_a = 16'h8000; s_b = 16'hFFFF;
    @(negedge clk);
    s_start = 1'b0; s_op = MD_NONE;
    check("w16_div_busy", s_busy, 1);
    @(negedge clk);
    check("w16_div_done", s_done, 1);
    check("w16_div_hilo", {s_hi, s_lo}, 32'h00008000);
    $display("txn w16 hi=%h lo=%h", s_hi, s_lo);

    // Reset during busy cycle 3 of a MULT discards it and clears HI/LO at once.
    issue(MD_MULT, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    check("rstmid_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_hi", hi, 0);
    check("rstmid_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bn = 0; dn = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy) bn++;
      if (done) dn++;
      @(negedge clk);
    end
    check("rstmid_after_busy", bn, 0);
    check("rstmid_after_done", dn, 0);
    check("rstmid_after_hilo", {hi, lo}, 0);
    $display("txn reset-mid hi=%h lo=%h", hi, lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
